// File: rtl/tpu_pkg.sv
// Shared arbitration constants and index-width helper for the mux family.
package tpu_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// Combinational rotating-priority picker: chooses one request, searching
// upward from ptr and wrapping, or from index 0 when rr is low.
module rr_pick
  import tpu_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  input  logic          rr,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] gnt_idx,
  output logic          any
);

  logic [N-1:0] hi_req;
  logic [N-1:0] pick_vec;
  logic         found;

  // Requests at or above the pointer take precedence; otherwise wrap to the
  // full request set and take the lowest index.
  always_comb begin
    hi_req   = '0;
    pick_vec = '0;
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      hi_req[i] = req[i] && (CW'(i) >= ptr);
    end
    pick_vec = (rr && (|hi_req)) ? hi_req : req;
    for (int i = 0; i < N; i++) begin
      if (pick_vec[i] && !found) begin
        gnt[i]  = 1'b1;
        gnt_idx = CW'(i);
        found   = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer with a single registered valid/ready
// output stage. Supports round-robin, fixed priority and forced selection.
module arb_mux_n
  import tpu_pkg::*;
#(
  parameter  int WIDTH = 17,
  parameter  int N     = 4,
  parameter  int RR    = 1,
  localparam int CW    = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 force_en,
  input  logic [CW-1:0]        force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    ptr_q, ptr_d;

  logic             load;
  logic [N-1:0]     force_mask;
  logic [N-1:0]     eligible;
  logic [N-1:0]     gnt;
  logic [CW-1:0]    gnt_idx;
  logic             any;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] chan_data [N];

  // Per-channel views of the packed input bus and the forced-select decode.
  // An out-of-range force_sel matches no channel, so nothing is eligible.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign chan_data[gi]  = in_data[gi*WIDTH +: WIDTH];
    assign force_mask[gi] = (force_sel == CW'(gi));
  end

  // The output register can take a new beat when empty or being drained.
  always_comb begin
    load     = !out_valid_q || out_ready;
    eligible = force_en ? (in_valid & force_mask) : in_valid;
  end

  rr_pick #(
    .N  (N),
    .CW (CW)
  ) u_pick (
    .req     (eligible),
    .ptr     (ptr_q),
    .rr      (RR == ARB_RR),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Handshake only the granted channel, and only when the stage can load.
  always_comb begin
    in_ready = (load && !rst) ? gnt : '0;
  end

  // Select the granted channel's data; the grant vector is one-hot.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        sel_data = chan_data[i];
      end
    end
  end

  // Next-state for the output stage and the round-robin pointer. Data and
  // channel index hold when nothing is loaded; the pointer only moves on a grant.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = sel_data;
        out_chan_d = gnt_idx;
        ptr_d      = (gnt_idx == CW'(N-1)) ? '0 : gnt_idx + CW'(1);
      end
    end
  end

  // State registers; reset discards any held beat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench for arb_mux_n: directed stimulus pushes hand-computed
// expected beats; per-instance monitors pop and compare on each accepted beat.
module tb_arb_mux_n;

  logic clk;
  logic rst;

  // Instance A (round-robin, N=4, WIDTH=17) and F (fixed priority) share inputs.
  logic [67:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic        a_force_en;
  logic [1:0]  a_force_sel;
  logic [16:0] a_out_data;
  logic [1:0]  a_out_chan;
  logic        a_out_valid;
  logic        a_out_ready;

  logic [3:0]  f_in_ready;
  logic [16:0] f_out_data;
  logic [1:0]  f_out_chan;
  logic        f_out_valid;

  // Instance B: N=2, WIDTH=34, round-robin.
  logic [67:0] b_in_data;
  logic [1:0]  b_in_valid;
  logic [1:0]  b_in_ready;
  logic        b_force_en;
  logic [0:0]  b_force_sel;
  logic [33:0] b_out_data;
  logic [0:0]  b_out_chan;
  logic        b_out_valid;
  logic        b_out_ready;

  // Instance C: N=5, WIDTH=8, round-robin (force_sel can exceed N-1).
  logic [39:0] c_in_data;
  logic [4:0]  c_in_valid;
  logic [4:0]  c_in_ready;
  logic        c_force_en;
  logic [2:0]  c_force_sel;
  logic [7:0]  c_out_data;
  logic [2:0]  c_out_chan;
  logic        c_out_valid;
  logic        c_out_ready;

  int vectors    = 0;
  int miscompares = 0;

  logic [18:0] qa [$];
  logic [34:0] qb [$];
  logic [18:0] a_exp;
  logic [34:0] b_exp;

  arb_mux_n #(.WIDTH(17), .N(4), .RR(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .force_en(a_force_en), .force_sel(a_force_sel),
    .out_data(a_out_data), .out_chan(a_out_chan), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  arb_mux_n #(.WIDTH(17), .N(4), .RR(0)) u_f (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(f_in_ready), .force_en(a_force_en), .force_sel(a_force_sel),
    .out_data(f_out_data), .out_chan(f_out_chan), .out_valid(f_out_valid),
    .out_ready(a_out_ready)
  );

  arb_mux_n #(.WIDTH(34), .N(2), .RR(1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .force_en(b_force_en), .force_sel(b_force_sel),
    .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  arb_mux_n #(.WIDTH(8), .N(5), .RR(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .force_en(c_force_en), .force_sel(c_force_sel),
    .out_data(c_out_data), .out_chan(c_out_chan), .out_valid(c_out_valid),
    .out_ready(c_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [1:0] c, input logic [16:0] d);
    qa.push_back({c, d});
  endtask

  // Monitor for instance A: one comparison per accepted output beat.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL a_beat: unexpected beat chan %0d data 0x%0h", a_out_chan, a_out_data);
      end else begin
        a_exp = qa.pop_front();
        chk("a_beat", 64'({a_out_chan, a_out_data}), 64'(a_exp));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_beat: unexpected beat chan %0d data 0x%0h", b_out_chan, b_out_data);
      end else begin
        b_exp = qb.pop_front();
        chk("b_beat", 64'({b_out_chan, b_out_data}), 64'(b_exp));
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_in_data = {17'h103, 17'h102, 17'h101, 17'h100};
    a_in_valid = 4'b1111; a_force_en = 1'b0; a_force_sel = 2'd0; a_out_ready = 1'b1;
    b_in_data = {34'h2_FFFF_0101, 34'h3_0000_0100};
    b_in_valid = 2'b00; b_force_en = 1'b0; b_force_sel = 1'b0; b_out_ready = 1'b1;
    c_in_data = {8'h44, 8'h43, 8'h42, 8'h41, 8'h40};
    c_in_valid = 5'b00000; c_force_en = 1'b0; c_force_sel = 3'd0; c_out_ready = 1'b1;

    // Reset state, and no handshake while reset is held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_out_chan", 64'(a_out_chan), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin with all channels valid: 0,1,2,3,0.
    push_a(2'd0, 17'h100); push_a(2'd1, 17'h101); push_a(2'd2, 17'h102);
    push_a(2'd3, 17'h103); push_a(2'd0, 17'h100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_in_ready", 64'(a_in_ready), 64'(4'b0001 << (k % 4)));
      step();
    end
    a_in_valid = 4'b0000;
    step();

    // Fixed priority on F; A (pointer now 1) alternates 1,3.
    a_in_valid = 4'b1010;
    push_a(2'd1, 17'h101); push_a(2'd3, 17'h103); push_a(2'd1, 17'h101); push_a(2'd3, 17'h103);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fp_in_ready", 64'(f_in_ready), 64'(4'b0010));
      if (k > 0) chk("fp_out_chan", 64'(f_out_chan), 64'd1);
      step();
    end
    a_in_valid = 4'b0000;
    step();

    // Backpressure: hold a beat three cycles, then drain and refill together.
    a_in_valid = 4'b1111;
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("bp_first_ready", 64'(a_in_ready), 64'(4'b0001));
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_data", 64'(a_out_data), 64'h100);
      chk("bp_hold_ready", 64'(a_in_ready), 64'd0);
      step();
    end
    push_a(2'd0, 17'h100); push_a(2'd1, 17'h101);
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_refill_ready", 64'(a_in_ready), 64'(4'b0010));
    step();
    a_in_valid = 4'b0000;
    @(negedge clk);
    chk("bp_no_bubble", 64'(a_out_valid), 64'd1);
    step();

    // Forced select of channel 2 (pointer now 2).
    a_force_en = 1'b1; a_force_sel = 2'd2; a_in_valid = 4'b1111;
    push_a(2'd2, 17'h102); push_a(2'd2, 17'h102); push_a(2'd2, 17'h102);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("force_in_ready", 64'(a_in_ready), 64'(4'b0100));
      step();
    end
    a_force_en = 1'b0; a_in_valid = 4'b0000;
    step();

    // Wrap: pointer at 3, then a lone request on channel 0, then all again.
    push_a(2'd3, 17'h103); push_a(2'd0, 17'h100); push_a(2'd1, 17'h101);
    a_in_valid = 4'b1111;
    @(negedge clk); chk("wrap_g3", 64'(a_in_ready), 64'(4'b1000)); step();
    a_in_valid = 4'b0001;
    @(negedge clk); chk("wrap_g0", 64'(a_in_ready), 64'(4'b0001)); step();
    a_in_valid = 4'b1111;
    @(negedge clk); chk("wrap_ptr1", 64'(a_in_ready), 64'(4'b0010)); step();
    a_in_valid = 4'b0000;
    step();

    // Reset in the middle of a held beat.
    a_in_data[16:0] = 17'h1ABCD;
    a_in_valid = 4'b0001;
    a_out_ready = 1'b0;
    step();
    a_in_valid = 4'b0000;
    @(negedge clk);
    chk("mid_held_valid", 64'(a_out_valid), 64'd1);
    chk("mid_held_data", 64'(a_out_data), 64'h1ABCD);
    #2;
    rst = 1'b1;
    a_in_valid = 4'b1111;
    a_out_ready = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_data", 64'(a_out_data), 64'd0);
    chk("mid_rst_chan", 64'(a_out_chan), 64'd0);
    chk("mid_rst_ready", 64'(a_in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("mid_rst_ready2", 64'(a_in_ready), 64'd0);
    step();
    rst = 1'b0;
    a_in_data[16:0] = 17'h100;
    push_a(2'd0, 17'h100);
    @(negedge clk);
    chk("post_rst_ptr0", 64'(a_in_ready), 64'(4'b0001));
    step();
    a_in_valid = 4'b0000;
    step();

    // N=2, WIDTH=34 round-robin.
    qb.push_back({1'b0, 34'h3_0000_0100}); qb.push_back({1'b1, 34'h2_FFFF_0101});
    qb.push_back({1'b0, 34'h3_0000_0100}); qb.push_back({1'b1, 34'h2_FFFF_0101});
    qb.push_back({1'b0, 34'h3_0000_0100});
    b_in_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("n2_in_ready", 64'(b_in_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      step();
    end
    b_in_valid = 2'b00;
    step();

    // N=5: force the top channel, then out-of-range selects give no grant.
    c_force_en = 1'b1; c_force_sel = 3'd4; c_in_valid = 5'b11111;
    @(negedge clk);
    chk("n5_force4_ready", 64'(c_in_ready), 64'(5'b10000));
    step();
    c_force_sel = 3'd5;
    @(negedge clk);
    chk("n5_beat_valid", 64'(c_out_valid), 64'd1);
    chk("n5_beat_chan", 64'(c_out_chan), 64'd4);
    chk("n5_beat_data", 64'(c_out_data), 64'h44);
    chk("n5_sel5_ready", 64'(c_in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("n5_drained", 64'(c_out_valid), 64'd0);
    step();
    c_force_sel = 3'd7;
    @(negedge clk);
    chk("n5_sel7_ready", 64'(c_in_ready), 64'd0);
    step();
    c_force_en = 1'b0;
    @(negedge clk);
    chk("n5_ptr_wrap", 64'(c_in_ready), 64'(5'b00001));
    step();
    c_in_valid = 5'b00000;
    step();
    step();

    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
